sbox_sw_conditioner: RTL

Input stage that sits directly upstream of the S-box datapath on the board. It synchronizes and debounces the raw slide switches: SW[7:0] is the data byte and SW[9] is the mode (1 = encrypt, 0 = decrypt). Each settled, changed switch setting is presented once to the S-box stage over a valid/ready handshake. This keeps switch bounce and metastability out of the S-box's store/encrypt/decrypt logic.

---
 rtl/sbox_sw_conditioner_if.sv | 27 ++
 rtl/sbox_sw_conditioner.sv | 101 ++++++++++
 2 files changed

// File: rtl/sbox_sw_conditioner_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sbox_sw_conditioner_if
// Brief   : valid/ready handshake carrying a committed switch setting
// Revision: 1.0
// ---------------------------------------------------------------------------
interface sbox_sw_conditioner_if;
  logic [7:0] out_data;
  logic       out_mode;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_mode,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_mode,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sbox_sw_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sbox_sw_conditioner
// Brief   : synchronizes and debounces slide switches, presents each settled
//           setting once; optional accept counter via SBOX_COND_CNT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module sbox_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic [9:0]            SW,
`ifdef SBOX_COND_CNT_EN
  output logic [7:0]            commit_cnt,
`endif
  sbox_sw_conditioner_if.master out_if
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  logic [8:0]       sync_meta;
  logic [8:0]       sw_sync;
  logic [8:0]       sample;
  logic [8:0]       committed;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             unused_sw8;

  assign unused_sw8 = SW[8];

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      sync_meta <= '0;
      sw_sync   <= '0;
    end else begin
      sync_meta <= {SW[9], SW[7:0]};
      sw_sync   <= sync_meta;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state            <= IDLE;
      sample           <= '0;
      committed        <= '0;
      cnt              <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= 8'h00;
      out_if.out_mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sw_sync != committed) begin
            sample <= sw_sync;
            cnt    <= '0;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          // Any movement restarts the full stability window.
          if (sw_sync != sample) begin
            sample <= sw_sync;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            {out_if.out_mode, out_if.out_data} <= sample;
            out_if.out_valid <= 1'b1;
            state            <= PRESENT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            committed        <= sample;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBOX_COND_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      commit_cnt <= 8'h00;
    end else if (out_if.out_valid && out_if.out_ready && commit_cnt != 8'hFF) begin
      commit_cnt <= commit_cnt + 8'h01;
    end
  end
`endif

endmodule
`default_nettype wire
